// File: rtl/fpu_op_sequencer.sv
// Purpose: queue operand pairs, drive them into the FPU adder with a per-op
//          reset pulse, and capture each result into a one-entry output slot.
// Latency: push edge e0 -> pop at e1 -> capture at e1+RST_CYCLES+FPU_LATENCY.
// Backpressure: in_ready drops while the FIFO is full. The sequencer stalls at
//               the end of WAIT, with operands held, while the result slot is full.
//
// Ports:
//   clock, reset (async, active-low)
//   in_valid/in_ready/in_op_A/in_op_B     operand-pair input handshake
//   fpu_reset/fpu_op_A/fpu_op_B           drive to the FPU adder
//   fpu_data_out/fpu_status_out           result from the FPU adder
//   res_valid/res_ready/res_data/res_status  result output handshake
//   busy, count                           sequencer activity and FIFO occupancy

// Generic operand FIFO. The caller guards push with !full and pop with !empty.
// The head entry is read combinationally. Pointers wrap modulo DEPTH, and the
// count tells full from empty.
module seq_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; an entry is only read after it has been written.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
endmodule

module fpu_op_sequencer #(
  parameter int DEPTH       = 4,
  parameter int RST_CYCLES  = 1,
  parameter int FPU_LATENCY = 6
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_op_A,
  input  logic [31:0]                in_op_B,
  output logic                       fpu_reset,
  output logic [31:0]                fpu_op_A,
  output logic [31:0]                fpu_op_B,
  input  logic [31:0]                fpu_data_out,
  input  logic [3:0]                 fpu_status_out,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [31:0]                res_data,
  output logic [3:0]                 res_status,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int CMAX   = (RST_CYCLES > FPU_LATENCY) ? RST_CYCLES : FPU_LATENCY;
  // The counter only ever holds a value up to CMAX-1.
  localparam int CW     = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] RST_LOAD  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LOAD = CW'(FPU_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, RST, WAIT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          push;
  logic          pop;
  logic          capture;
  logic          fifo_empty;
  logic [63:0]   head;

  assign in_ready   = (count != CNT_W'(DEPTH));
  assign push       = in_valid && in_ready;
  assign fifo_empty = (count == '0);

  seq_fifo #(
    .WIDTH (64),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_dat ({in_op_A, in_op_B}),
    .pop      (pop),
    .head_dat (head),
    .count    (count)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pop       = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        // An entry pushed on this edge is not visible yet, so there is no bypass.
        if (!fifo_empty) begin
          pop       = 1'b1;
          cnt_nxt   = RST_LOAD;
          state_nxt = RST;
        end
      end
      RST: begin
        if (cnt == '0) begin
          cnt_nxt   = WAIT_LOAD;
          state_nxt = WAIT;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      WAIT: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else if (!res_valid || res_ready) begin
          capture   = 1'b1;
          state_nxt = IDLE;
        end
        // With the slot full, stay here at count 0 with the operands held.
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Operands change only when an entry is popped.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fpu_op_A <= '0;
      fpu_op_B <= '0;
    end else if (pop) begin
      {fpu_op_A, fpu_op_B} <= head;
    end
  end

  // A capture takes priority over a drain, so a capture and a drain on the
  // same edge replace the slot contents and leave it full.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_status <= '0;
    end else if (capture) begin
      res_valid  <= 1'b1;
      res_data   <= fpu_data_out;
      res_status <= fpu_status_out;
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

  assign busy      = (state != IDLE);
  assign fpu_reset = reset && (state != RST);
endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Bench for fpu_op_sequencer: a scheduling model (queue plus elapsed-time
// rule) checked every cycle, plus directed scenarios with literal results.
// A second instance runs with RST_CYCLES=2, FPU_LATENCY=3.
module tb_fpu_op_sequencer;
  localparam int DEPTH = 4;
  localparam int RSTC  = 1;
  localparam int LAT   = 6;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_op_A, in_op_B;
  logic        fpu_reset;
  logic [31:0] fpu_op_A, fpu_op_B, fpu_data_out;
  logic [3:0]  fpu_status_out;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic [3:0]  res_status;
  logic        busy;
  logic [2:0]  count;

  logic        in_valid2, in_ready2;
  logic [31:0] in_op_A2, in_op_B2;
  logic        fpu_reset2;
  logic [31:0] fpu_op_A2, fpu_op_B2, fpu_data_out2;
  logic [3:0]  fpu_status_out2;
  logic        res_valid2, res_ready2;
  logic [31:0] res_data2;
  logic [3:0]  res_status2;
  logic        busy2;
  logic [2:0]  count2;

  logic [3:0]  phase;
  int          cyc;
  int          checks   = 0;
  int          failures = 0;

  // FPU stand-in: known sums for the directed pairs, integer add otherwise.
  function automatic logic [31:0] fpu_fn(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3E000000, 32'h3E000000}: return 32'h40000000;
      {32'h40000000, 32'h40000000}: return 32'h42000000;
      {32'h3E000000, 32'hBE000000}: return 32'h00000000;
      {32'h3F000000, 32'h3C000000}: return 32'h40000000;
      {32'h3E000000, 32'h00000000}: return 32'h3E000000;
      default:                      return a + b;
    endcase
  endfunction

  assign fpu_data_out    = fpu_fn(fpu_op_A, fpu_op_B);
  assign fpu_status_out  = phase;
  assign fpu_data_out2   = fpu_fn(fpu_op_A2, fpu_op_B2);
  assign fpu_status_out2 = phase;

  fpu_op_sequencer #(.DEPTH(DEPTH), .RST_CYCLES(RSTC), .FPU_LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op_A(in_op_A), .in_op_B(in_op_B), .fpu_reset(fpu_reset),
    .fpu_op_A(fpu_op_A), .fpu_op_B(fpu_op_B), .fpu_data_out(fpu_data_out),
    .fpu_status_out(fpu_status_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_status(res_status), .busy(busy), .count(count)
  );

  fpu_op_sequencer #(.DEPTH(DEPTH), .RST_CYCLES(2), .FPU_LATENCY(3)) dut2 (
    .clock(clock), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_op_A(in_op_A2), .in_op_B(in_op_B2), .fpu_reset(fpu_reset2),
    .fpu_op_A(fpu_op_A2), .fpu_op_B(fpu_op_B2), .fpu_data_out(fpu_data_out2),
    .fpu_status_out(fpu_status_out2), .res_valid(res_valid2), .res_ready(res_ready2),
    .res_data(res_data2), .res_status(res_status2), .busy(busy2), .count(count2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scheduling model ----------------
  logic [63:0] mq[$];
  int          n    = 0;
  bit          m_inflight;
  int          m_pe;
  logic [31:0] m_a, m_b, m_rd;
  logic [3:0]  m_rs;
  bit          m_rv;
  bit          m_cap, m_pop, m_push;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_inflight = 0; m_pe = 0; m_a = '0; m_b = '0;
      m_rv = 0; m_rd = '0; m_rs = '0;
    end else begin
      n++;
      // An op popped at edge p may be captured from edge p+RSTC+LAT onward,
      // as soon as the result slot is free.
      m_cap  = m_inflight && ((n - m_pe) >= RSTC + LAT) && (!m_rv || res_ready);
      m_pop  = !m_inflight && (mq.size() > 0);
      m_push = in_valid && (mq.size() < DEPTH);
      if (m_cap) begin
        m_rv = 1; m_rd = fpu_fn(m_a, m_b); m_rs = phase; m_inflight = 0;
      end else if (m_rv && res_ready) begin
        m_rv = 0;
      end
      if (m_pop) begin
        {m_a, m_b} = mq.pop_front();
        m_inflight = 1;
        m_pe = n;
      end
      if (m_push) mq.push_back({in_op_A, in_op_B});
    end
  end

  always @(negedge clock) begin
    check("in_ready", in_ready, mq.size() < DEPTH);
    check("count", count, mq.size());
    check("busy", busy, m_inflight);
    check("fpu_reset", fpu_reset, reset && !(m_inflight && ((n - m_pe) < RSTC)));
    check("fpu_op_A", fpu_op_A, m_a);
    check("fpu_op_B", fpu_op_B, m_b);
    check("res_valid", res_valid, m_rv);
    if (m_rv) begin
      check("res_data", res_data, m_rd);
      check("res_status", res_status, m_rs);
    end
  end

  // Drained results and peak occupancy, observed from the DUT.
  logic [31:0] got[$];
  int          got_t[$];
  int          peak;
  always @(negedge clock) begin
    if (reset && res_valid && res_ready) begin
      got.push_back(res_data);
      got_t.push_back(cyc);
    end
    if (int'(count) > peak) peak = int'(count);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    phase = phase + 4'd1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    int k = 0;
    in_valid = 1'b1; in_op_A = a; in_op_B = b;
    while (!in_ready && k < 100) begin tick(); k++; end
    check("push_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  // Count edges from a push until res_valid, with fpu_reset-low and operand-hold tallies.
  task automatic run_latency(input logic [31:0] a, input logic [31:0] b,
                             output int lat, output int lowc, output int stab,
                             output logic [3:0] st);
    lat = 0; lowc = 0; stab = 0; st = '0;
    push(a, b);
    while (!res_valid && lat < 50) begin
      st = phase;
      tick();
      lat++;
      if (!fpu_reset) lowc++;
      if (busy && fpu_reset && fpu_op_A == a && fpu_op_B == b) stab++;
    end
  endtask

  logic [31:0] burst_a [4] = '{32'h40000000, 32'h3E000000, 32'h3F000000, 32'h3E000000};
  logic [31:0] burst_b [4] = '{32'h40000000, 32'hBE000000, 32'h3C000000, 32'h00000000};
  logic [31:0] burst_r [4] = '{32'h42000000, 32'h00000000, 32'h40000000, 32'h3E000000};
  logic [31:0] full_a  [6] = '{32'h11111111, 32'h22222222, 32'h33333333,
                               32'h44444444, 32'h55555555, 32'h66666666};
  logic [31:0] full_r  [6] = '{32'h11111112, 32'h22222224, 32'h33333336,
                               32'h44444448, 32'h5555555A, 32'h6666666C};

  initial begin
    int lat, lowc, stab, k;
    logic [3:0] st;
    reset = 1'b1; in_valid = 0; in_op_A = '0; in_op_B = '0; res_ready = 1'b1;
    in_valid2 = 0; in_op_A2 = '0; in_op_B2 = '0; res_ready2 = 1'b1;
    phase = '0; cyc = 0; peak = 0;
    #2 reset = 1'b0;
    repeat (2) tick();
    check("rst_count", count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_fpu_reset", fpu_reset, 0);
    check("rst_op_A", fpu_op_A, 0);
    check("rst_res_data", res_data, 0);
    reset = 1'b1;
    repeat (2) tick();

    // Single op
    run_latency(32'h3E000000, 32'h3E000000, lat, lowc, stab, st);
    check("single_latency", lat, 8);
    check("single_rst_low", lowc, 1);
    check("single_stable", stab, 6);
    check("single_data", res_data, 32'h40000000);
    check("single_status", res_status, st);
    tick();
    check("single_op_held", fpu_op_A, 32'h3E000000);
    repeat (3) tick();

    // Back-to-back burst
    got.delete(); got_t.delete(); peak = 0;
    for (int i = 0; i < 4; i++) push(burst_a[i], burst_b[i]);
    k = 0;
    while (got.size() < 4 && k < 100) begin tick(); k++; end
    check("burst_n", got.size(), 4);
    check("burst_peak", (peak == 3 || peak == 4), 1);
    for (int i = 0; i < 4 && i < got.size(); i++) check("burst_res", got[i], burst_r[i]);
    for (int i = 1; i < got_t.size(); i++) check("burst_gap", got_t[i] - got_t[i-1], 8);
    repeat (3) tick();

    // Full FIFO, stall, then drain with a capture/drain collision
    got.delete(); got_t.delete();
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(full_a[i], 32'(i + 1));
    check("full_count", count, 4);
    check("full_in_ready", in_ready, 0);
    push(full_a[5], 32'd6);
    repeat (10) tick();
    check("stall_busy", busy, 1);
    check("stall_res_valid", res_valid, 1);
    check("stall_res_data", res_data, 32'h11111112);
    check("stall_op_A", fpu_op_A, 32'h22222222);
    check("stall_fpu_reset", fpu_reset, 1);
    check("stall_count", count, 4);
    res_ready = 1'b1;
    tick();
    check("collide_valid", res_valid, 1);
    check("collide_data", res_data, 32'h22222224);
    k = 0;
    while (got.size() < 6 && k < 100) begin tick(); k++; end
    repeat (10) tick();
    check("drain_n", got.size(), 6);
    for (int i = 0; i < 6 && i < got.size(); i++) check("drain_res", got[i], full_r[i]);

    // Reset mid-operation with two entries queued
    got.delete();
    for (int i = 0; i < 3; i++) push(32'h0A000000 + 32'(i), 32'h1);
    repeat (2) tick();
    check("pre_rst_count", count, 2);
    reset = 1'b0;
    #1;
    check("midrst_count", count, 0);
    check("midrst_res_valid", res_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_fpu_reset", fpu_reset, 0);
    tick();
    reset = 1'b1;
    repeat (20) tick();
    check("no_stale", got.size(), 0);
    run_latency(32'h3F000000, 32'h3C000000, lat, lowc, stab, st);
    check("post_rst_latency", lat, 8);
    check("post_rst_data", res_data, 32'h40000000);
    repeat (3) tick();

    // Parameter sweep instance: RST_CYCLES=2, FPU_LATENCY=3
    in_valid2 = 1'b1; in_op_A2 = 32'h3E000000; in_op_B2 = 32'h3E000000;
    check("sweep_in_ready", in_ready2, 1);
    tick();
    in_valid2 = 1'b0;
    lat = 0; lowc = 0;
    while (!res_valid2 && lat < 50) begin
      tick();
      lat++;
      if (!fpu_reset2) lowc++;
    end
    check("sweep_latency", lat, 6);
    check("sweep_rst_low", lowc, 2);
    check("sweep_data", res_data2, 32'h40000000);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fpu_op_sequencer.md
# fpu_op_sequencer

Upstream feeder and result collector for the FPU adder. Accepts operand pairs over a valid/ready handshake into a small FIFO and presents each pair to the FPU with a per-operation FPU reset pulse. Operands are held stable for a fixed latency, then `data_out`/`status_out` are captured into a result register with its own valid/ready handshake. Operand format is 32 bits: sign[31], exponent[30:25] (bias 31), mantissa[24:0].

## Interface
- `DEPTH`, 4: operand-pair FIFO entries; power of two, ≥2.
- `RST_CYCLES`, 1: cycles `fpu_reset` is held low per operation, ≥1.
- `FPU_LATENCY`, 6: cycles operands are held with `fpu_reset` high before capture, ≥1.

- `clock` in 1: single clock; all state on rising edge.
- `reset` in 1: **asynchronous, active-low** reset of the whole block.
- `in_valid` in 1: operand pair offered.
- `in_ready` out 1: FIFO not full.
- `in_op_A` in 32: operand A.
- `in_op_B` in 32: operand B.
- `fpu_reset` out 1: active-low reset to FPU.
- `fpu_op_A` out 32: to FPU `op_A_in`.
- `fpu_op_B` out 32: to FPU `op_B_in`.
- `fpu_data_out` in 32: from FPU `data_out`.
- `fpu_status_out` in 4: from FPU `status_out`, treated as opaque.
- `res_valid` out 1: result register full.
- `res_ready` in 1: consumer accepts result.
- `res_data` out 32: captured FPU result.
- `res_status` out 4: captured FPU status.
- `busy` out 1: state ≠ IDLE.
- `count` out $clog2(DEPTH+1): FIFO occupancy.

## Operation
- Push on `in_valid && in_ready`; `in_ready = (count != DEPTH)`. Pointers wrap modulo DEPTH; an extra wrap bit or the count distinguishes full from empty.
- States: IDLE, RST, WAIT.
- **IDLE:** when the FIFO is non-empty, on the edge:
  - pop the head into `fpu_op_A`/`fpu_op_B`;
  - load the counter with RST_CYCLES-1;
  - go to RST.
- **RST:** `fpu_reset` = 0.
  - At counter 0, load counter with FPU_LATENCY-1 and go to WAIT; otherwise decrement.
- **WAIT:** `fpu_reset` = 1; decrement the counter to 0.
  - At counter 0 with the result slot free (`!res_valid || res_ready`):
    - capture `res_data <= fpu_data_out`, `res_status <= fpu_status_out`, `res_valid <= 1`;
    - go to IDLE.
  - At counter 0 with the slot full: stay in WAIT with counter 0 and operands held. This stall has no timeout.
- `fpu_op_A`/`fpu_op_B` change only on a pop edge. They hold their value in RST, WAIT and IDLE.
- `fpu_reset = reset && (state != RST)`: a combinational function of registered state and the block reset.
- Result drain: `res_valid` clears on `res_valid && res_ready` unless a capture occurs on the same edge. Capture and drain on the same edge leave `res_valid` = 1 with the new data.
- Push and pop on the same edge: count is unchanged.
- Push into an empty FIFO is popped no earlier than the next edge; there is no bypass.

## Timing
- Reset values (asynchronous, while `reset` = 0):
  - state IDLE, counter 0, FIFO empty, `count` 0;
  - `fpu_op_A` = `fpu_op_B` = 0, `res_data` 0, `res_status` 0, `res_valid` 0, `busy` 0, `fpu_reset` 0;
  - `in_ready` = 1 once the FIFO is cleared.
- Reset mid-operation abandons the in-flight operation and all queued operations. No result is produced for them.
- Latency: push edge e0 → pop at e1 → RST for RST_CYCLES → WAIT for FPU_LATENCY → capture at edge e1+RST_CYCLES+FPU_LATENCY. `res_valid` goes high after that edge. With defaults this is 8 edges after e0.
- Throughput with `res_ready` held high: one operation every RST_CYCLES+FPU_LATENCY+1 cycles (8 with defaults).

## Test plan
- **Single op:**
  - Stimulus: push A=0x3E000000 (1.0), B=0x3E000000 (1.0) with `res_ready`=1.
  - Required: `fpu_reset` is low for exactly 1 cycle; operands are stable for 6 cycles; `res_valid` rises 8 edges after the push; `res_data`=0x40000000 (2.0); `res_status` equals the `fpu_status_out` sampled at the capture edge.
- **Back-to-back burst:** push 4 pairs on consecutive cycles.
  - Pairs: (0x40000000, 0x40000000), (0x3E000000, 0xBE000000), (0x3F000000, 0x3C000000), (0x3E000000, 0x00000000).
  - Required: results in order 0x42000000, 0x00000000, 0x40000000, 0x3E000000, spaced 8 cycles apart; `count` peaks at 3 or 4.
- **Full FIFO:** with `res_ready`=0, push 6 pairs.
  - Required: `in_ready` drops when `count`=4.
  - The first result is held in `res_data`; the sequencer stalls in WAIT with operands held.
  - Raising `res_ready` drains all results in order; pointer wrap-around is exercised.
- **Capture/drain collision:** `res_ready` is asserted on the same edge a new capture occurs.
  - Required: `res_valid` stays 1, `res_data` updates, and no result is lost or duplicated.
- **Reset mid-operation:** assert `reset`=0 while in WAIT with 2 entries queued.
  - Required, immediately: `count`=0, `res_valid`=0, `busy`=0, `fpu_reset`=0.
  - Required after release: no stale results appear, and a new push completes normally in 8 cycles.
- **Parameter sweep:** run with RST_CYCLES=2, FPU_LATENCY=3.
  - Required: `fpu_reset` is low for 2 cycles and capture occurs 6 edges after the push.
